ncl_ring_supervisor: RTL

Clocked supervisor for the dual-rail NCL oscillation rings. It drives the ring's `init` line with a programmable-length pulse and samples the completion and rail signals of one tap stage through synchronizers. From those samples it counts wavefronts, measures the oscillation period and detects stalls and illegal rail codes. A stalled ring is re-initialized automatically up to a retry limit. The block sits between the bench or system controller and any ring instance, and is the only driver of that ring's `init`.

---
 rtl/ncl_ring_pkg.sv | 18 +
 rtl/ncl_sync2.sv | 21 ++
 rtl/ncl_ring_supervisor.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ncl_ring_pkg.sv
// Shared types and constants for the NCL ring supervisor.
package ncl_ring_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_HOLD,
    ST_RELEASE,
    ST_RUN,
    ST_STALL,
    ST_FAULT
  } ring_sup_state_t;

  localparam int RETRY_W = 4;

  // Both rails asserted at once is never a legal dual-rail code
  localparam logic [1:0] RAIL_ILLEGAL = 2'b11;

endpackage

// File: rtl/ncl_sync2.sv
// Two-flop synchronizer for one asynchronous ring signal, clears to 0 on reset.
module ncl_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ncl_ring_supervisor.sv
// Supervisor for one dual-rail NCL oscillation ring: pulses the ring's init,
// watches a tap stage for wavefronts, measures the period and recovers stalls.
module ncl_ring_supervisor
  import ncl_ring_pkg::*;
#(
  parameter int INIT_CYCLES  = 20,
  parameter int STALL_CYCLES = 64,
  parameter int CNT_W        = 16,
  parameter int MAX_RETRY    = 3
) (
  input  logic               clk,
  input  logic               init,
  input  logic               start,
  input  logic               abort,
  input  logic               tap_comp,
  input  logic [1:0]         tap_rail,
  output logic               ring_init,
  output logic               running,
  output logic               stalled,
  output logic               fault,
  output logic [CNT_W-1:0]   wave_count,
  output logic [CNT_W-1:0]   period,
  output logic               period_valid,
  output logic [RETRY_W-1:0] retries
);

  localparam int HOLD_W  = $clog2(INIT_CYCLES + 1);
  localparam int STALL_W = $clog2(STALL_CYCLES);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(INIT_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

  ring_sup_state_t    state, state_next;
  logic               comp_sync, comp_prev, wave_det;
  logic [1:0]         rail_sync;
  logic               rail_ill_prev, illegal;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [STALL_W-1:0] stall_tmr;
  logic [CNT_W-1:0]   period_cnt;
  logic               have_first;
  logic               active, timeout, enter_hold, count_wave;

  ncl_sync2 u_sync_comp  (.clk(clk), .rst(init), .d(tap_comp),    .q(comp_sync));
  ncl_sync2 u_sync_rail0 (.clk(clk), .rst(init), .d(tap_rail[0]), .q(rail_sync[0]));
  ncl_sync2 u_sync_rail1 (.clk(clk), .rst(init), .d(tap_rail[1]), .q(rail_sync[1]));

  always_ff @(posedge clk or posedge init) begin
    if (init) state <= ST_IDLE;
    else      state <= state_next;
  end

  // A wavefront in the timeout cycle suppresses the timeout; abort overrides all
  always_comb begin
    active     = (state == ST_RELEASE) || (state == ST_RUN);
    illegal    = (rail_sync == RAIL_ILLEGAL) && rail_ill_prev;
    timeout    = active && (stall_tmr == STALL_LAST) && !wave_det;
    state_next = state;
    case (state)
      ST_IDLE, ST_STALL, ST_FAULT: begin
        if (start) state_next = ST_INIT_HOLD;
      end
      ST_INIT_HOLD: begin
        if (hold_cnt == HOLD_LAST) state_next = ST_RELEASE;
      end
      ST_RELEASE, ST_RUN: begin
        if (illegal)       state_next = ST_FAULT;
        else if (timeout)  state_next = (retries < RETRY_MAX) ? ST_INIT_HOLD : ST_STALL;
        else if (wave_det) state_next = ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
    enter_hold = (state_next == ST_INIT_HOLD) && (state != ST_INIT_HOLD);
    count_wave = wave_det && (state_next == ST_RUN);
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      comp_prev     <= 1'b0;
      wave_det      <= 1'b0;
      rail_ill_prev <= 1'b0;
    end else begin
      comp_prev     <= comp_sync;
      wave_det      <= comp_sync & ~comp_prev;
      rail_ill_prev <= (rail_sync == RAIL_ILLEGAL);
    end
  end

  // Status flags are decoded from the next state so they settle with it
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      ring_init <= 1'b1;
      running   <= 1'b0;
      stalled   <= 1'b0;
      fault     <= 1'b0;
    end else begin
      ring_init <= !((state_next == ST_RELEASE) || (state_next == ST_RUN));
      running   <= (state_next == ST_RUN);
      stalled   <= (state_next == ST_STALL);
      fault     <= (state_next == ST_FAULT);
    end
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      hold_cnt  <= '0;
      stall_tmr <= '0;
    end else begin
      if (state == ST_INIT_HOLD) hold_cnt <= hold_cnt + 1'b1;
      else                       hold_cnt <= '0;
      if (active && !wave_det && !timeout) stall_tmr <= stall_tmr + 1'b1;
      else                                 stall_tmr <= '0;
    end
  end

  // Period counter restarts at 1 on each counted wavefront and saturates
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      wave_count   <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      period_cnt   <= '0;
      have_first   <= 1'b0;
      retries      <= '0;
    end else begin
      if (enter_hold) retries <= active ? retries + 1'b1 : '0;
      if (enter_hold) begin
        wave_count   <= '0;
        period_valid <= 1'b0;
        have_first   <= 1'b0;
      end else if (count_wave) begin
        wave_count <= wave_count + 1'b1;
        period_cnt <= CNT_W'(1);
        have_first <= 1'b1;
        if (have_first) begin
          period       <= period_cnt;
          period_valid <= 1'b1;
        end
      end else if ((state == ST_RUN) && (state_next == ST_RUN) && (period_cnt != '1)) begin
        period_cnt <= period_cnt + 1'b1;
      end
    end
  end

endmodule
